dds_wave_shaper: RTL and testbench

Downstream stage of the DDS phase accumulator. It consumes the 8-bit phase address each clock and produces an amplitude-scaled 8-bit offset-binary sample for the DAC. Four waveform shapes are supported: sine from a quarter-wave table, square, triangle and sawtooth. It is a 3-register pipeline with a valid strobe, so upstream may insert bubbles.

---
 rtl/dds_pkg.sv | 34 +++
 rtl/sine_qtr_rom.sv | 35 +++
 rtl/dds_wave_shaper.sv | 109 ++++++++++
 tb/tb_dds_wave_shaper.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS wave shaper datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dds_pkg;

  localparam int ADDR_W    = 8;
  localparam int SAMPLE_W  = 8;
  localparam int QTR_DEPTH = 64;
  localparam int QTR_IDX_W = $clog2(QTR_DEPTH);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } wave_mode_e;

  // Signed full-scale values; -128 is never produced so the output stays off the rails.
  localparam logic [SAMPLE_W-1:0] W_POS_FS = 8'h7F;  // +127
  localparam logic [SAMPLE_W-1:0] W_NEG_FS = 8'h81;  // -127

  // Everything that travels with a sample through the input register.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    wave_mode_e          mode;
    logic [SAMPLE_W-1:0] amp;
  } s1_t;

  // Two's-complement negate of an 8-bit waveform value.
  function automatic logic [SAMPLE_W-1:0] neg8(input logic [SAMPLE_W-1:0] x);
    return 8'd0 - x;
  endfunction

endpackage

// File: rtl/sine_qtr_rom.sv
// Quarter-wave sine table: Q[k] = round(127*sin(pi*(2k+1)/256)), k = 0..63.
// Latency: combinational.
// Backpressure: none.
// Ports: idx - table index (0..63); val - 7-bit unsigned magnitude.
module sine_qtr_rom
  import dds_pkg::*;
(
  input  logic [QTR_IDX_W-1:0] idx,
  output logic [6:0]           val
);

  always_comb begin
    val = '0;
    case (idx)
      6'd0:  val = 7'd2;   6'd1:  val = 7'd5;   6'd2:  val = 7'd8;   6'd3:  val = 7'd11;
      6'd4:  val = 7'd14;  6'd5:  val = 7'd17;  6'd6:  val = 7'd20;  6'd7:  val = 7'd23;
      6'd8:  val = 7'd26;  6'd9:  val = 7'd29;  6'd10: val = 7'd32;  6'd11: val = 7'd35;
      6'd12: val = 7'd38;  6'd13: val = 7'd41;  6'd14: val = 7'd44;  6'd15: val = 7'd47;
      6'd16: val = 7'd50;  6'd17: val = 7'd53;  6'd18: val = 7'd56;  6'd19: val = 7'd58;
      6'd20: val = 7'd61;  6'd21: val = 7'd64;  6'd22: val = 7'd67;  6'd23: val = 7'd69;
      6'd24: val = 7'd72;  6'd25: val = 7'd74;  6'd26: val = 7'd77;  6'd27: val = 7'd79;
      6'd28: val = 7'd82;  6'd29: val = 7'd84;  6'd30: val = 7'd86;  6'd31: val = 7'd89;
      6'd32: val = 7'd91;  6'd33: val = 7'd93;  6'd34: val = 7'd95;  6'd35: val = 7'd97;
      6'd36: val = 7'd99;  6'd37: val = 7'd101; 6'd38: val = 7'd103; 6'd39: val = 7'd105;
      6'd40: val = 7'd106; 6'd41: val = 7'd108; 6'd42: val = 7'd110; 6'd43: val = 7'd111;
      6'd44: val = 7'd113; 6'd45: val = 7'd114; 6'd46: val = 7'd115; 6'd47: val = 7'd117;
      6'd48: val = 7'd118; 6'd49: val = 7'd119; 6'd50: val = 7'd120; 6'd51: val = 7'd121;
      6'd52: val = 7'd122; 6'd53: val = 7'd123; 6'd54: val = 7'd124; 6'd55: val = 7'd124;
      6'd56: val = 7'd125; 6'd57: val = 7'd125; 6'd58: val = 7'd126; 6'd59: val = 7'd126;
      6'd60: val = 7'd127; 6'd61: val = 7'd127; 6'd62: val = 7'd127; 6'd63: val = 7'd127;
      default: val = '0;
    endcase
  end

endmodule

// File: rtl/dds_wave_shaper.sv
// Phase address -> amplitude-scaled offset-binary DAC sample (sine/square/triangle/saw).
// Latency: 3 register stages (valid at edge N -> sample_valid after edge N+2), 1 sample/clk.
// Backpressure: none; upstream may insert bubbles via addr_valid, output holds while invalid.
// Ports: clk, rst (sync, active-high); addr_in/addr_valid/mode/amp in; sample/sample_valid out.
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int OUT_MID = 128,
  parameter bit INVERT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic                addr_valid,
  input  logic [1:0]          mode,
  input  logic [SAMPLE_W-1:0] amp,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid
);

  localparam logic [SAMPLE_W-1:0] MID = 8'(OUT_MID);

  // ---------------- S1: input register ----------------
  s1_t  s1_q;
  logic v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else begin
      v1 <= addr_valid;
      if (addr_valid) begin
        s1_q <= '{addr: addr_in, mode: wave_mode_e'(mode), amp: amp};
      end
    end
  end

  // ---------------- S2: shape ----------------
  logic [QTR_IDX_W-1:0] qtr_idx;
  logic [6:0]           qtr_val;
  logic [SAMPLE_W-1:0]  w_shape;
  logic [SAMPLE_W-1:0]  w_fin;

  // Odd quadrants (addr[6] = 1) read the table backwards: 63 - i == ~i.
  assign qtr_idx = s1_q.addr[6] ? ~s1_q.addr[5:0] : s1_q.addr[5:0];

  sine_qtr_rom u_sine_qtr_rom (
    .idx (qtr_idx),
    .val (qtr_val)
  );

  always_comb begin
    w_shape = '0;
    case (s1_q.mode)
      // Second half-cycle (addr[7] = 1) is the negated first half.
      MODE_SINE:   w_shape = s1_q.addr[7] ? neg8({1'b0, qtr_val}) : {1'b0, qtr_val};
      MODE_SQUARE: w_shape = s1_q.addr[7] ? W_NEG_FS : W_POS_FS;
      // 8-bit wraparound gives the right two's-complement result; range is +/-127.
      MODE_TRI:    w_shape = s1_q.addr[7] ? (8'd127 - {s1_q.addr[6:0], 1'b0})
                                          : ({s1_q.addr[6:0], 1'b0} - 8'd127);
      // addr - 128 is just an MSB flip; addr 0 would give -128, clamp to -127.
      MODE_SAW:    w_shape = (s1_q.addr == 8'h00) ? W_NEG_FS
                                                  : {~s1_q.addr[7], s1_q.addr[6:0]};
      default:     w_shape = '0;
    endcase
    w_fin = INVERT ? neg8(w_shape) : w_shape;
  end

  logic [SAMPLE_W-1:0] w2;
  logic [SAMPLE_W-1:0] amp2;
  logic                v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      w2   <= '0;
      amp2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        w2   <= w_fin;
        amp2 <= s1_q.amp;
      end
    end
  end

  // ---------------- S3: scale and offset ----------------
  // |w*amp| <= 127*255 fits a 16-bit signed product; amp is zero-extended (unsigned).
  logic signed [15:0]  prod;
  logic [SAMPLE_W-1:0] sample_next;

  assign prod        = $signed({{8{w2[7]}}, w2}) * $signed({8'd0, amp2});
  // Arithmetic shift floors toward -inf; only the low byte of the sum reaches the DAC.
  assign sample_next = 8'((prod >>> 8) + $signed({8'd0, MID}));

  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= MID;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= v2;
      if (v2) begin
        sample <= sample_next;
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_shaper.sv
module tb_dds_wave_shaper;

  localparam real PI = 3.14159265358979;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_in;
  logic       addr_valid;
  logic [1:0] mode;
  logic [7:0] amp;
  logic [7:0] sample, sample_i;
  logic       sample_valid, sample_valid_i;

  always #5 clk = ~clk;

  dds_wave_shaper #(.OUT_MID(128), .INVERT(1'b0)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
    .mode(mode), .amp(amp), .sample(sample), .sample_valid(sample_valid)
  );

  dds_wave_shaper #(.OUT_MID(128), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
    .mode(mode), .amp(amp), .sample(sample_i), .sample_valid(sample_valid_i)
  );

  typedef struct {
    logic [7:0] smp;
    logic [7:0] smp_inv;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         n_asserts = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  bit         chk_en    = 1'b0;
  logic [7:0] held      = 8'd128;
  logic [7:0] held_i    = 8'd128;
  string      step_name = "init";

  // Reference waveform value from the continuous definitions.
  function automatic int model_w(input logic [7:0] a, input logic [1:0] m);
    real x;
    int  w;
    w = 0;
    case (m)
      2'd0: begin
        x = 127.0 * $sin(PI * (2.0 * a + 1.0) / 256.0);
        w = (x < 0.0) ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5);
      end
      2'd1: w = (a < 8'd128) ? 127 : -127;
      2'd2: w = (a < 8'd128) ? (2 * int'(a) - 127) : (127 - 2 * (int'(a) - 128));
      2'd3: begin
        w = int'(a) - 128;
        if (w < -127) w = -127;
      end
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] model_smp(input logic [7:0] a, input logic [1:0] m,
                                           input logic [7:0] am, input bit inv);
    int w, p, s;
    w = model_w(a, m);
    if (inv) w = -w;
    p = w * int'(am);
    s = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
    return 8'(s + 128);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s [%s] cyc %0d: observed %0d expected %0d", tag, step_name, cyc, obs, exp);
    end
  endtask

  // Advance one clock and compare both DUT outputs with the scoreboard.
  task automatic cycle();
    bit   ev;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      ev = (sb.size() > 0) && (sb[0].due == cyc);
      chk("sample_valid", {15'd0, sample_valid}, {15'd0, ev});
      chk("sample_valid_inv", {15'd0, sample_valid_i}, {15'd0, ev});
      if (ev) begin
        e      = sb.pop_front();
        held   = e.smp;
        held_i = e.smp_inv;
      end
      chk("sample", {8'd0, sample}, {8'd0, held});
      chk("sample_inv", {8'd0, sample_i}, {8'd0, held_i});
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [1:0] m,
                       input logic [7:0] am);
    addr_valid = v;
    addr_in    = a;
    mode       = m;
    amp        = am;
    if (v && !rst)
      sb.push_back('{model_smp(a, m, am, 1'b0), model_smp(a, m, am, 1'b1), cyc + 3});
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h5A, 2'd0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; addr_valid = 1'b0; addr_in = '0; mode = '0; amp = '0;
    cycle(); cycle();
    chk_en = 1'b1;
    step_name = "reset_state";
    cycle();
    rst = 1'b0;

    step_name = "sine_amp255";
    drive(1, 8'h00, 2'd0, 8'd255);
    drive(1, 8'h40, 2'd0, 8'd255);
    drive(1, 8'h80, 2'd0, 8'd255);
    drive(1, 8'hC0, 2'd0, 8'd255);
    idle(3);

    step_name = "square";
    drive(1, 8'h7F, 2'd1, 8'd128);
    drive(1, 8'h80, 2'd1, 8'd128);
    drive(1, 8'h33, 2'd1, 8'd0);
    drive(1, 8'hC5, 2'd0, 8'd0);
    idle(3);

    step_name = "triangle_saw";
    drive(1, 8'h00, 2'd2, 8'd255);
    drive(1, 8'h7F, 2'd2, 8'd255);
    drive(1, 8'h80, 2'd2, 8'd255);
    drive(1, 8'hFF, 2'd2, 8'd255);
    drive(1, 8'h00, 2'd3, 8'd255);
    drive(1, 8'h80, 2'd3, 8'd255);
    drive(1, 8'hFF, 2'd3, 8'd255);
    idle(3);

    step_name = "bubbles";
    drive(1, 8'h40, 2'd0, 8'd255);
    drive(0, 8'hAA, 2'd0, 8'd255);
    drive(1, 8'hC0, 2'd0, 8'd255);
    idle(3);

    step_name = "mode_amp_switch";
    drive(1, 8'h40, 2'd0, 8'd255);
    drive(1, 8'h40, 2'd3, 8'd255);
    drive(1, 8'h40, 2'd0, 8'd128);
    drive(1, 8'h40, 2'd0, 8'd255);
    idle(3);

    step_name = "reset_flush";
    drive(1, 8'h20, 2'd0, 8'd200);
    drive(1, 8'h90, 2'd2, 8'd200);
    rst = 1'b1;
    sb.delete();
    held = 8'd128;
    held_i = 8'd128;
    drive(1, 8'h40, 2'd0, 8'd255);
    drive(1, 8'h80, 2'd1, 8'd255);
    rst = 1'b0;
    idle(3);
    step_name = "after_reset";
    drive(1, 8'h40, 2'd0, 8'd255);
    idle(3);

    step_name = "random";
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 8'($urandom));
    idle(4);

    step_name = "drain";
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
